char_plane_scroll: RTL and testbench

Parametrised successor to the fixed 16x40 character plane. It is a ROWS x COLS character buffer with a registered read port for the text renderer and a direct write port. It adds a teletype-style cursor port with auto-advance, newline, hardware scroll-up via a row offset, and a sequenced clear engine. It sits between the text/console logic and the pixel renderer that fetches character IDs per cell.

---
 rtl/char_plane_scroll.sv | 185 ++++++++++++++++++
 tb/tb_char_plane_scroll.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_plane_scroll.sv
// ROWS x COLS character plane with a registered read port, a direct write port,
// a teletype-style cursor with hardware scroll-up, and a sequenced clear engine.
module char_plane_scroll #(
    parameter int ROWS   = 16,
    parameter int COLS   = 40,
    parameter int CHAR_W = 8,
    parameter int ROW_W  = 4,
    parameter int COL_W  = 6,
    parameter logic [CHAR_W-1:0] BLANK = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [CHAR_W-1:0] rd_char,
    input  logic              wr_en,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [CHAR_W-1:0] wr_char,
    input  logic              put_en,
    input  logic [CHAR_W-1:0] put_char,
    input  logic              newline,
    input  logic              clear_req,
    output logic [ROW_W-1:0]  cur_row,
    output logic [COL_W-1:0]  cur_col,
    output logic              busy
);

    localparam int CELLS  = ROWS * COLS;
    localparam int ADDR_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [ROW_W:0]    ROWS_X    = (ROW_W+1)'(ROWS);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] LAST_IDXC = ADDR_W'(COLS - 1);

    typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_ROW} state_t;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [CHAR_W-1:0] data;
    } wr_req_t;

    logic [CHAR_W-1:0] mem [CELLS];

    state_t            state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [ROW_W-1:0]  top, top_n;
    logic [ROW_W-1:0]  cur_row_n;
    logic [COL_W-1:0]  cur_col_n;
    wr_req_t           wr;
    logic              scroll;
    logic              rd_ok;
    logic [ADDR_W-1:0] rd_addr;

    // Logical row -> physical row; the sum keeps one extra bit so the wrap test is exact.
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] lrow,
                                                  input logic [ROW_W-1:0] t);
        logic [ROW_W:0] sum;
        sum = {1'b0, lrow} + {1'b0, t};
        if (sum >= ROWS_X)
            sum = sum - ROWS_X;
        return sum[ROW_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(int'(prow) * COLS + int'(col));
    endfunction

    function automatic logic in_range(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        return (int'(r) < ROWS) && (int'(c) < COLS);
    endfunction

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        top_n     = top;
        cur_row_n = cur_row;
        cur_col_n = cur_col;
        wr        = '0;
        scroll    = 1'b0;

        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n   = CLR_ALL;
                    idx_n     = '0;
                    top_n     = '0;
                    cur_row_n = '0;
                    cur_col_n = '0;
                end else if (newline) begin
                    if (cur_row < LAST_ROW) begin
                        cur_row_n = cur_row + 1'b1;
                        cur_col_n = '0;
                    end else begin
                        scroll = 1'b1;
                    end
                end else if (put_en) begin
                    wr.en   = 1'b1;
                    wr.addr = cell_addr(phys_row(cur_row, top), cur_col);
                    wr.data = put_char;
                    if (cur_col < LAST_COL) begin
                        cur_col_n = cur_col + 1'b1;
                    end else if (cur_row < LAST_ROW) begin
                        cur_row_n = cur_row + 1'b1;
                        cur_col_n = '0;
                    end else begin
                        scroll = 1'b1;
                    end
                end else if (wr_en && in_range(wr_row, wr_col)) begin
                    wr.en   = 1'b1;
                    wr.addr = cell_addr(phys_row(wr_row, top), wr_col);
                    wr.data = wr_char;
                end
            end
            CLR_ALL: begin
                wr.en   = 1'b1;
                wr.addr = idx;
                wr.data = BLANK;
                if (idx == LAST_CELL)
                    state_n = IDLE;
                else
                    idx_n = idx + 1'b1;
            end
            CLR_ROW: begin
                // top has already advanced, so logical ROWS-1 is the old top row.
                wr.en   = 1'b1;
                wr.addr = cell_addr(phys_row(LAST_ROW, top), COL_W'(idx));
                wr.data = BLANK;
                if (idx == LAST_IDXC)
                    state_n = IDLE;
                else
                    idx_n = idx + 1'b1;
            end
            default: state_n = CLR_ALL;
        endcase

        // The put that triggers a scroll already wrote above, so its character moves up with the plane.
        if (scroll) begin
            top_n     = (top == LAST_ROW) ? '0 : top + 1'b1;
            cur_row_n = LAST_ROW;
            cur_col_n = '0;
            idx_n     = '0;
            state_n   = CLR_ROW;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLR_ALL;
            idx     <= '0;
            top     <= '0;
            cur_row <= '0;
            cur_col <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            top     <= top_n;
            cur_row <= cur_row_n;
            cur_col <= cur_col_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr.en)
            mem[wr.addr] <= wr.data;
    end

    assign rd_ok   = in_range(rd_row, rd_col);
    assign rd_addr = cell_addr(phys_row(rd_row, top), rd_col);

    // Same-cycle write/read of one cell returns the old word: the array updates on this same edge.
    always_ff @(posedge clk) begin
        if (reset)
            rd_char <= BLANK;
        else
            rd_char <= rd_ok ? mem[rd_addr] : BLANK;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_char_plane_scroll.sv
// Bench for char_plane_scroll: a logical-screen model with row shifting checks every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_char_plane_scroll;

    localparam int ROWS   = 16;
    localparam int COLS   = 40;
    localparam int CHAR_W = 8;
    localparam int ROW_W  = 5;
    localparam int COL_W  = 6;
    localparam logic [7:0] BLANK = 8'h00;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ROW_W-1:0]  rd_row = '0;
    logic [COL_W-1:0]  rd_col = '0;
    logic [CHAR_W-1:0] rd_char;
    logic              wr_en = 1'b0;
    logic [ROW_W-1:0]  wr_row = '0;
    logic [COL_W-1:0]  wr_col = '0;
    logic [CHAR_W-1:0] wr_char = '0;
    logic              put_en = 1'b0;
    logic [CHAR_W-1:0] put_char = '0;
    logic              newline = 1'b0;
    logic              clear_req = 1'b0;
    logic [ROW_W-1:0]  cur_row;
    logic [COL_W-1:0]  cur_col;
    logic              busy;

    always #5 clk = ~clk;

    char_plane_scroll #(
        .ROWS(ROWS), .COLS(COLS), .CHAR_W(CHAR_W), .ROW_W(ROW_W), .COL_W(COL_W), .BLANK(BLANK)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_row(rd_row), .rd_col(rd_col), .rd_char(rd_char),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char),
        .put_en(put_en), .put_char(put_char), .newline(newline), .clear_req(clear_req),
        .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: logical screen; scrolling shifts rows up, busy is a countdown of ignored cycles.
    logic [7:0] scr [ROWS][COLS];
    int         m_busy = 0;
    int         m_cr = 0;
    int         m_cc = 0;
    bit         started = 1'b0;
    bit         exp_chk = 1'b0;
    logic [7:0] exp_rd = 8'h00;

    task automatic m_blank_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = BLANK;
    endtask

    task automatic m_scroll();
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = scr[r+1][c];
        for (int c = 0; c < COLS; c++)
            scr[ROWS-1][c] = BLANK;
        m_cr   = ROWS - 1;
        m_cc   = 0;
        m_busy = COLS;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            started = 1'b1;
            exp_chk = 1'b1;
            exp_rd  = BLANK;
            m_blank_all();
            m_busy = ROWS * COLS;
            m_cr   = 0;
            m_cc   = 0;
        end else begin
            exp_chk = (m_busy == 0);
            exp_rd  = (int'(rd_row) >= ROWS || int'(rd_col) >= COLS) ? BLANK : scr[rd_row][rd_col];
            if (m_busy > 0) begin
                m_busy--;
            end else if (clear_req) begin
                m_blank_all();
                m_busy = ROWS * COLS;
                m_cr   = 0;
                m_cc   = 0;
            end else if (newline) begin
                if (m_cr < ROWS - 1) begin
                    m_cr++;
                    m_cc = 0;
                end else begin
                    m_scroll();
                end
            end else if (put_en) begin
                scr[m_cr][m_cc] = put_char;
                if (m_cc < COLS - 1) m_cc++;
                else if (m_cr < ROWS - 1) begin
                    m_cr++;
                    m_cc = 0;
                end else m_scroll();
            end else if (wr_en && int'(wr_row) < ROWS && int'(wr_col) < COLS) begin
                scr[wr_row][wr_col] = wr_char;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (started) begin
            check("busy", {31'b0, busy}, {31'b0, (m_busy != 0)});
            check("cur_row", 32'(cur_row), 32'(m_cr));
            check("cur_col", 32'(cur_col), 32'(m_cc));
            if (exp_chk)
                check("rd_char", 32'(rd_char), 32'(exp_rd));
        end
    end

    task automatic put(input logic [7:0] ch);
        put_en = 1'b1; put_char = ch;
        @(negedge clk);
        put_en = 1'b0;
    endtask

    task automatic nl();
        newline = 1'b1;
        @(negedge clk);
        newline = 1'b0;
    endtask

    task automatic wr(input int r, input int c, input logic [7:0] ch);
        wr_en = 1'b1; wr_row = ROW_W'(r); wr_col = COL_W'(c); wr_char = ch;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd_lit(input int r, input int c, input logic [7:0] exp, input string name);
        rd_row = ROW_W'(r); rd_col = COL_W'(c);
        @(negedge clk);
        check(name, 32'(rd_char), 32'(exp));
    endtask

    task automatic read_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                rd_row = ROW_W'(r); rd_col = COL_W'(c);
                @(negedge clk);
            end
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 5000) check("busy_timeout", 32'(n), 32'(0));
    endtask

    initial begin
        int n;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        busy_len(n);
        check("reset_busy_len", 32'(n), 32'd640);
        check("reset_cur_row", 32'(cur_row), 32'd0);
        check("reset_cur_col", 32'(cur_col), 32'd0);
        read_all();

        wr(3, 10, 8'h41);
        rd_lit(3, 10, 8'h41, "wr_read");
        rd_lit(16, 0, 8'h00, "rd_row_oob");
        rd_lit(0, 40, 8'h00, "rd_col_oob");
        rd_lit(31, 63, 8'h00, "rd_both_oob");
        wr(20, 5, 8'h33);
        wr(2, 45, 8'h34);
        read_all();

        for (int i = 1; i <= 41; i++) put(8'(i));
        check("put41_cur_row", 32'(cur_row), 32'd1);
        check("put41_cur_col", 32'(cur_col), 32'd1);
        rd_lit(0, 0, 8'd1, "put_r0c0");
        rd_lit(0, 39, 8'd40, "put_r0c39");
        rd_lit(1, 0, 8'd41, "put_r1c0");

        for (int i = 0; i < 14; i++) nl();
        for (int i = 0; i < 39; i++) put(8'h80 + 8'(i));
        check("pre_scroll_cur_row", 32'(cur_row), 32'd15);
        check("pre_scroll_cur_col", 32'(cur_col), 32'd39);
        put(8'h5A);
        busy_len(n);
        check("scroll_busy_len", 32'(n), 32'd40);
        check("scroll_cur_row", 32'(cur_row), 32'd15);
        check("scroll_cur_col", 32'(cur_col), 32'd0);
        rd_lit(14, 39, 8'h5A, "scroll_r14c39");
        rd_lit(14, 0, 8'h80, "scroll_r14c0");
        rd_lit(15, 0, 8'h00, "scroll_r15c0");
        rd_lit(0, 0, 8'd41, "scroll_old_row1");
        rd_lit(2, 10, 8'h41, "scroll_old_row3");
        read_all();

        // Enough bottom-row newlines to carry top all the way round.
        for (int i = 0; i < 17; i++) begin
            nl();
            busy_len(n);
            check("nl_scroll_busy_len", 32'(n), 32'd40);
            put(8'hC0 + 8'(i));
        end
        read_all();

        clear_req = 1'b1; put_en = 1'b1; put_char = 8'h77;
        @(negedge clk);
        clear_req = 1'b0; put_en = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            if (n == 5) begin
                put_en = 1'b1; wr_en = 1'b1; newline = 1'b1; clear_req = 1'b1;
                wr_row = 5'd2; wr_col = 6'd2; wr_char = 8'h99; put_char = 8'h55;
            end else if (n == 7) begin
                put_en = 1'b0; wr_en = 1'b0; newline = 1'b0; clear_req = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        check("clear_busy_len", 32'(n), 32'd640);
        check("clear_cur_row", 32'(cur_row), 32'd0);
        check("clear_cur_col", 32'(cur_col), 32'd0);
        rd_lit(0, 0, 8'h00, "clear_r0c0");
        rd_lit(2, 2, 8'h00, "clear_r2c2");
        read_all();

        put(8'h11); put(8'h12); put(8'h13);
        for (int i = 0; i < 20; i++) nl();
        busy_len(n);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        busy_len(n);
        check("rst_mid_busy_len", 32'(n), 32'd640);
        check("rst_mid_cur_row", 32'(cur_row), 32'd0);
        check("rst_mid_cur_col", 32'(cur_col), 32'd0);
        read_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
